shift_rows_pipe: RTL and testbench

- Parametrised, pipelined Rijndael ShiftRows/InvShiftRows unit for the HEA datapath.
- Supports block widths of 128, 192 and 256 bits (NB = 4, 6 or 8 columns).
- Encrypt/decrypt direction is selected per transaction at run time, not at elaboration.
- Valid/ready handshake on both sides, with full backpressure through a PIPE_DEPTH-stage register pipeline; a sideband tag travels with each block.

---
 rtl/shift_rows_pipe.sv | 210 +++++++++++++++++++++
 tb/tb_shift_rows_pipe.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe
// ---------------
// Pipelined Rijndael ShiftRows / InvShiftRows for 128-, 192- and 256-bit
// blocks (NB = 4, 6 or 8 columns). Each block selects its direction with
// in_dec_i. The byte permutation is combinational in front of stage 0.
// Stages 1..PIPE_DEPTH-1 only carry the state and the tag. Full valid/ready
// backpressure is supported, and empty stages collapse so that bubbles
// disappear while the output is stalled.
//
// Optional build macro SHIFT_ROWS_PARITY_EN:
//   Carries a 4-bit row-parity vector with each block and checks it again at
//   the output. It adds the output port par_err_o.
//
// Ports:
//   clk_i        clock (rising edge)
//   rst_i        synchronous reset, active high (priority over flush_i)
//   flush_i      synchronous pipeline clear (valid bits only)
//   in_valid_i   input block valid
//   in_ready_o   unit accepts a block this cycle
//   in_dec_i     1 = InvShiftRows, 0 = ShiftRows
//   in_state_i   input state, byte 0 in the MSB, column-major
//   in_tag_i     sideband tag
//   out_valid_o  output block valid
//   out_ready_i  downstream accepts
//   out_state_o  permuted state
//   out_tag_o    tag of the output block
//   par_err_o    (SHIFT_ROWS_PARITY_EN only) row-parity mismatch on output
//   busy_o       at least one stage holds a valid block
module shift_rows_pipe #(
  parameter int NB         = 4,
  parameter int PIPE_DEPTH = 1,
  parameter int TAG_W      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  in_dec_i,
  input  logic [32*NB-1:0]      in_state_i,
  input  logic [TAG_W-1:0]      in_tag_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [32*NB-1:0]      out_state_o,
  output logic [TAG_W-1:0]      out_tag_o,
`ifdef SHIFT_ROWS_PARITY_EN
  output logic                  par_err_o,
`endif
  output logic                  busy_o
);

  localparam int SW     = 32 * NB;
  localparam int NBYTES = 4 * NB;
  localparam int LAST   = PIPE_DEPTH - 1;

  // Reject unsupported configurations during elaboration.
  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (PIPE_DEPTH < 1 || PIPE_DEPTH > 4) begin : g_bad_depth
    $error("shift_rows_pipe: PIPE_DEPTH must be in 1..4");
  end

  // Row rotation amount. The 256-bit block uses larger shifts for rows 2
  // and 3.
  function automatic int row_off(input int r);
    if (NB == 8 && r >= 2) begin
      return r + 1;
    end
    return r;
  endfunction

  // --------------------------------------------------------------------
  // Combinational permutation. Both directions are wired as fixed byte
  // routings, and in_dec_i selects between them.
  // --------------------------------------------------------------------
  logic [SW-1:0] enc_state;
  logic [SW-1:0] dec_state;
  logic [SW-1:0] perm_state;

  for (genvar gi = 0; gi < NB; gi++) begin : g_col
    for (genvar gj = 0; gj < 4; gj++) begin : g_row
      localparam int ENC_SRC = (gi + row_off(gj)) % NB;
      localparam int DEC_SRC = (gi - row_off(gj) + NB) % NB;
      localparam int DST     = 4 * gi + gj;
      assign enc_state[8*(NBYTES-1-DST) +: 8] =
        in_state_i[8*(NBYTES-1-(4*ENC_SRC+gj)) +: 8];
      assign dec_state[8*(NBYTES-1-DST) +: 8] =
        in_state_i[8*(NBYTES-1-(4*DEC_SRC+gj)) +: 8];
    end
  end

  assign perm_state = in_dec_i ? dec_state : enc_state;

  // --------------------------------------------------------------------
  // Pipeline registers
  // --------------------------------------------------------------------
  logic [PIPE_DEPTH-1:0]            v_reg,     v_next;
  logic [PIPE_DEPTH-1:0][SW-1:0]    state_reg, state_next;
  logic [PIPE_DEPTH-1:0][TAG_W-1:0] tag_reg,   tag_next;

  // Values presented to each stage by its upstream neighbour.
  logic [PIPE_DEPTH-1:0]            up_v;
  logic [PIPE_DEPTH-1:0][SW-1:0]    up_state;
  logic [PIPE_DEPTH-1:0][TAG_W-1:0] up_tag;

  // take[k]: stage k loads its upstream value on the next edge.
  logic [PIPE_DEPTH-1:0]            take;

`ifdef SHIFT_ROWS_PARITY_EN
  logic [PIPE_DEPTH-1:0][3:0]       par_reg, par_next;
  logic [PIPE_DEPTH-1:0][3:0]       up_par;

  // One bit per row: XOR of every bit of every byte in that row. ShiftRows
  // only moves bytes within a row, so this vector is invariant.
  function automatic logic [3:0] row_parity(input logic [SW-1:0] s);
    logic [3:0] p;
    p = '0;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        p[r] = p[r] ^ (^s[8*(NBYTES-1-(4*c+r)) +: 8]);
      end
    end
    return p;
  endfunction
`endif

  for (genvar gi = 0; gi < PIPE_DEPTH; gi++) begin : g_stage
    // Stage k can take a block if any stage from k to the end is empty, or
    // if the output drains this cycle. This flattened form avoids a
    // combinational chain through take[] and has no path from in_valid_i.
    assign take[gi] = out_ready_i | ~(&v_reg[LAST:gi]);

    if (gi == 0) begin : g_head
      assign up_v[gi]     = in_valid_i;
      assign up_state[gi] = perm_state;
      assign up_tag[gi]   = in_tag_i;
`ifdef SHIFT_ROWS_PARITY_EN
      assign up_par[gi]   = row_parity(in_state_i);
`endif
    end else begin : g_body
      assign up_v[gi]     = v_reg[gi-1];
      assign up_state[gi] = state_reg[gi-1];
      assign up_tag[gi]   = tag_reg[gi-1];
`ifdef SHIFT_ROWS_PARITY_EN
      assign up_par[gi]   = par_reg[gi-1];
`endif
    end
  end

  always_comb begin
    v_next     = v_reg;
    state_next = state_reg;
    tag_next   = tag_reg;
`ifdef SHIFT_ROWS_PARITY_EN
    par_next   = par_reg;
`endif
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      if (take[k]) begin
        v_next[k] = up_v[k];
        // Data only moves when a real block arrives. Bubbles leave the
        // payload registers untouched.
        if (up_v[k]) begin
          state_next[k] = up_state[k];
          tag_next[k]   = up_tag[k];
`ifdef SHIFT_ROWS_PARITY_EN
          par_next[k]   = up_par[k];
`endif
        end
      end
    end
    // A flush drops every in-flight block and also any block offered in
    // the same cycle.
    if (flush_i) begin
      v_next = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_reg     <= '0;
      state_reg <= '0;
      tag_reg   <= '0;
`ifdef SHIFT_ROWS_PARITY_EN
      par_reg   <= '0;
`endif
    end else begin
      v_reg     <= v_next;
      state_reg <= state_next;
      tag_reg   <= tag_next;
`ifdef SHIFT_ROWS_PARITY_EN
      par_reg   <= par_next;
`endif
    end
  end

  // --------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------
  assign in_ready_o  = take[0];
  assign out_valid_o = v_reg[LAST];
  assign out_state_o = state_reg[LAST];
  assign out_tag_o   = tag_reg[LAST];
  assign busy_o      = |v_reg;

`ifdef SHIFT_ROWS_PARITY_EN
  assign par_err_o = v_reg[LAST] & (row_parity(state_reg[LAST]) != par_reg[LAST]);
`endif

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Self-checking bench for shift_rows_pipe. Four instances cover these cases:
//   a: NB=4 PIPE_DEPTH=1  (known-answer vectors, back-to-back enc/dec)
//   b: NB=8 PIPE_DEPTH=3  (256-bit offsets, latency, optional parity)
//   c: NB=4 PIPE_DEPTH=2  (backpressure / stall)
//   d: NB=6 PIPE_DEPTH=4  (flush, reset mid-stream, 192-bit blocks)
// Expected blocks come from a reference model. They are pushed when a block
// is accepted and popped when the DUT presents it.
module tb_shift_rows_pipe;

  typedef struct packed {
    logic [255:0] st;
    logic [3:0]   tag;
  } ent_t;

  logic clk = 1'b0;
  logic rst, flush, dec;
  logic [3:0] tag;

  logic a_iv, a_ir, a_ov, a_or, a_busy;
  logic [127:0] a_is, a_os;
  logic [3:0] a_ot;
  logic b_iv, b_ir, b_ov, b_or, b_busy;
  logic [255:0] b_is, b_os;
  logic [3:0] b_ot;
  logic c_iv, c_ir, c_ov, c_or, c_busy;
  logic [127:0] c_is, c_os;
  logic [3:0] c_ot;
  logic d_iv, d_ir, d_ov, d_or, d_busy;
  logic [191:0] d_is, d_os;
  logic [3:0] d_ot;
`ifdef SHIFT_ROWS_PARITY_EN
  logic a_pe, b_pe, c_pe, d_pe;
`endif

  ent_t qa[$], qb[$], qc[$], qd[$];
  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  shift_rows_pipe #(.NB(4), .PIPE_DEPTH(1), .TAG_W(4)) dut_a (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(a_iv), .in_ready_o(a_ir),
    .in_dec_i(dec), .in_state_i(a_is), .in_tag_i(tag), .out_valid_o(a_ov),
    .out_ready_i(a_or), .out_state_o(a_os), .out_tag_o(a_ot),
`ifdef SHIFT_ROWS_PARITY_EN
    .par_err_o(a_pe),
`endif
    .busy_o(a_busy));

  shift_rows_pipe #(.NB(8), .PIPE_DEPTH(3), .TAG_W(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(b_iv), .in_ready_o(b_ir),
    .in_dec_i(dec), .in_state_i(b_is), .in_tag_i(tag), .out_valid_o(b_ov),
    .out_ready_i(b_or), .out_state_o(b_os), .out_tag_o(b_ot),
`ifdef SHIFT_ROWS_PARITY_EN
    .par_err_o(b_pe),
`endif
    .busy_o(b_busy));

  shift_rows_pipe #(.NB(4), .PIPE_DEPTH(2), .TAG_W(4)) dut_c (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(c_iv), .in_ready_o(c_ir),
    .in_dec_i(dec), .in_state_i(c_is), .in_tag_i(tag), .out_valid_o(c_ov),
    .out_ready_i(c_or), .out_state_o(c_os), .out_tag_o(c_ot),
`ifdef SHIFT_ROWS_PARITY_EN
    .par_err_o(c_pe),
`endif
    .busy_o(c_busy));

  shift_rows_pipe #(.NB(6), .PIPE_DEPTH(4), .TAG_W(4)) dut_d (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(d_iv), .in_ready_o(d_ir),
    .in_dec_i(dec), .in_state_i(d_is), .in_tag_i(tag), .out_valid_o(d_ov),
    .out_ready_i(d_or), .out_state_o(d_os), .out_tag_o(d_ot),
`ifdef SHIFT_ROWS_PARITY_EN
    .par_err_o(d_pe),
`endif
    .busy_o(d_busy));

  // Reference model. The state sits in the low 32*nb bits, byte i at
  // bits 8*(4*nb-1-i), and byte index i = 4*column + row.
  function automatic logic [255:0] model(input int nb, input logic d, input logic [255:0] s);
    logic [7:0]   b [32];
    logic [255:0] o;
    int off, src;
    o = '0;
    for (int i = 0; i < 32; i++) b[i] = 8'h00;
    for (int i = 0; i < 4*nb; i++) b[i] = s[8*(4*nb-1-i) +: 8];
    for (int c = 0; c < nb; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (r == 0)      off = 0;
        else if (r == 1) off = 1;
        else             off = (nb == 8) ? r + 1 : r;
        src = d ? (c - off + nb) % nb : (c + off) % nb;
        o[8*(4*nb-1-(4*c+r)) +: 8] = b[4*src+r];
      end
    end
    return o;
  endfunction

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", nm, got, exp);
    end
  endtask

  // Scoreboard step for one instance: pop and compare when an output
  // transfers, and push the expected result when an input transfers.
  `define SB(NM, OV, ORDY, OS, OT, Q, IV, IR, IS, NBV) \
    if ((OV) && (ORDY)) begin \
      vectors++; \
      assert (Q.size() > 0) else begin \
        errors++; \
        $error("FAIL %s_extra: observed output tag %0h, expected no output", NM, OT); \
      end \
      if (Q.size() > 0) begin \
        e = Q.pop_front(); \
        chk({NM, "_state"}, 256'(OS), e.st); \
        chk({NM, "_tag"}, 256'(OT), 256'(e.tag)); \
      end \
    end \
    if ((IV) && (IR) && !flush && !rst) begin \
      e.st  = model(NBV, dec, 256'(IS)); \
      e.tag = tag; \
      Q.push_back(e); \
    end

  // Called right after the inputs are driven at a falling edge. It samples
  // the handshakes for the coming rising edge, then advances one cycle.
  task automatic tick();
    ent_t e;
    #1;
    `SB("a", a_ov, a_or, a_os, a_ot, qa, a_iv, a_ir, a_is, 4)
    `SB("b", b_ov, b_or, b_os, b_ot, qb, b_iv, b_ir, b_is, 8)
    `SB("c", c_ov, c_or, c_os, c_ot, qc, c_iv, c_ir, c_is, 4)
    `SB("d", d_ov, d_or, d_os, d_ot, qd, d_iv, d_ir, d_is, 6)
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [255:0] enc_b;
    logic [127:0] prev_os;
    logic [3:0]   prev_ot;
    logic         prev_stall, saw_block, acc_in, acc_out;
    int n, sent, got;
    ent_t e2;

    rst = 1'b1; flush = 1'b0; dec = 1'b0; tag = 4'h0;
    a_iv = 0; b_iv = 0; c_iv = 0; d_iv = 0;
    a_or = 0; b_or = 0; c_or = 0; d_or = 0;
    a_is = '0; b_is = '0; c_is = '0; d_is = '0;
    tick(); tick();
    rst = 1'b0;
    #1;

    // ---- reset state, with out_ready low so in_ready depends only on empty stages
    chk("a_rst_valid", 256'(a_ov), 256'(0)); chk("a_rst_busy", 256'(a_busy), 256'(0));
    chk("a_rst_ready", 256'(a_ir), 256'(1)); chk("a_rst_state", 256'(a_os), 256'(0));
    chk("b_rst_valid", 256'(b_ov), 256'(0)); chk("b_rst_ready", 256'(b_ir), 256'(1));
    chk("b_rst_state", 256'(b_os), 256'(0)); chk("b_rst_tag", 256'(b_ot), 256'(0));
    chk("c_rst_busy", 256'(c_busy), 256'(0)); chk("d_rst_busy", 256'(d_busy), 256'(0));
    chk("d_rst_ready", 256'(d_ir), 256'(1)); chk("d_rst_state", 256'(d_os), 256'(0));

    // ---- NB=4 known-answer ShiftRows, latency 1, valid for one cycle
    a_or = 1; dec = 0; tag = 4'h1;
    a_is = 128'hd42711aee0bf98f1b8b45de51e415230; a_iv = 1;
    tick(); a_iv = 0;
    chk("a_enc_valid", 256'(a_ov), 256'(1));
    chk("a_enc_kat", 256'(a_os), 256'(128'hd4bf5d30e0b452aeb84111f11e2798e5));
    tick();
    chk("a_enc_one_cycle", 256'(a_ov), 256'(0));

    // ---- NB=4 known-answer InvShiftRows
    dec = 1; tag = 4'h2;
    a_is = 128'hd4bf5d30e0b452aeb84111f11e2798e5; a_iv = 1;
    tick(); a_iv = 0;
    chk("a_dec_valid", 256'(a_ov), 256'(1));
    chk("a_dec_kat", 256'(a_os), 256'(128'hd42711aee0bf98f1b8b45de51e415230));
    chk("a_dec_tag", 256'(a_ot), 256'(2));
    tick();

    // ---- alternating enc/dec back to back, tags 0..7, one result per cycle
    for (int i = 0; i < 8; i++) begin
      dec = i[0]; tag = i[3:0];
      a_is = {$urandom, $urandom, $urandom, $urandom}; a_iv = 1;
      tick();
      chk("a_b2b_valid", 256'(a_ov), 256'(1));
      chk("a_b2b_tag", 256'(a_ot), 256'(i));
    end
    a_iv = 0;
    tick();
    chk("a_b2b_drained", 256'(qa.size()), 256'(0));

    // ---- NB=8: offsets {0,1,3,4}, latency 3, decrypt round trip
    b_or = 1; dec = 0; tag = 4'h3;
    b_is = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    b_iv = 1;
    tick(); b_iv = 0;
    chk("b_lat1", 256'(b_ov), 256'(0));
    tick();
    chk("b_lat2", 256'(b_ov), 256'(0));
    tick();
    chk("b_lat3", 256'(b_ov), 256'(1));
    chk("b_out10", 256'(b_os[240 +: 8]), 256'(8'h05));
    chk("b_out20", 256'(b_os[232 +: 8]), 256'(8'h0e));
    chk("b_out30", 256'(b_os[224 +: 8]), 256'(8'h13));
    enc_b = b_os;
    tick();
    dec = 1; tag = 4'h4; b_is = enc_b; b_iv = 1;
    tick(); b_iv = 0;
    tick(); tick();
    chk("b_dec_valid", 256'(b_ov), 256'(1));
    chk("b_dec_roundtrip", b_os,
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    tick();

    // ---- PIPE_DEPTH=2 stall: out_ready low for cycles 3..6
    n = 0; sent = 0; got = 0; prev_stall = 0; saw_block = 0;
    prev_os = '0; prev_ot = '0;
    for (int k = 0; k < 16; k++) begin
      c_or = !(k >= 3 && k <= 6);
      c_iv = (sent < 6);
      if (c_iv) begin
        tag = sent[3:0]; dec = sent[0];
        c_is = {$urandom, $urandom, $urandom, $urandom};
      end
      #1;
      chk("c_in_ready", 256'(c_ir), 256'((n < 2) || c_or));
      if (!c_ir) saw_block = 1;
      if (prev_stall) begin
        chk("c_hold_valid", 256'(c_ov), 256'(1));
        chk("c_hold_state", 256'(c_os), 256'(prev_os));
        chk("c_hold_tag", 256'(c_ot), 256'(prev_ot));
      end
      prev_stall = c_ov && !c_or; prev_os = c_os; prev_ot = c_ot;
      acc_in  = c_iv && c_ir;
      acc_out = c_ov && c_or;
      if (acc_in)  sent++;
      if (acc_out) got++;
      n = n + int'(acc_in) - int'(acc_out);
      tick();
    end
    c_iv = 0;
    chk("c_backpressure_seen", 256'(saw_block), 256'(1));
    chk("c_all_emerged", 256'(got), 256'(6));
    chk("c_queue_empty", 256'(qc.size()), 256'(0));

    // ---- PIPE_DEPTH=4 flush with the pipe full
    d_or = 0;
    for (int i = 0; i < 4; i++) begin
      tag = 4'(i + 1); dec = i[0];
      d_is = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}; d_iv = 1;
      tick();
    end
    chk("d_full_valid", 256'(d_ov), 256'(1));
    chk("d_full_ready", 256'(d_ir), 256'(0));
    flush = 1; d_iv = 1; tag = 4'hf;
    tick();
    flush = 0; d_iv = 0;
    qd.delete();
    chk("d_flush_valid", 256'(d_ov), 256'(0));
    chk("d_flush_busy", 256'(d_busy), 256'(0));
    chk("d_flush_ready", 256'(d_ir), 256'(1));
    d_or = 1;
    repeat (6) tick();
    chk("d_flush_quiet", 256'(d_ov), 256'(0));

    // ---- NB=6 traffic through the 4-stage pipe
    for (int i = 0; i < 3; i++) begin
      tag = 4'(i + 8); dec = i[0];
      d_is = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}; d_iv = 1;
      tick();
    end
    d_iv = 0;
    repeat (5) tick();
    chk("d_nb6_drained", 256'(qd.size()), 256'(0));

    // ---- reset mid-stream
    d_or = 0;
    for (int i = 0; i < 4; i++) begin
      tag = 4'(i + 1); dec = i[0];
      d_is = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}; d_iv = 1;
      tick();
    end
    chk("d_prerst_valid", 256'(d_ov), 256'(1));
    rst = 1; d_iv = 1;
    tick();
    rst = 0; d_iv = 0;
    qd.delete();
    chk("d_rst_valid", 256'(d_ov), 256'(0));
    chk("d_rst_busy2", 256'(d_busy), 256'(0));
    chk("d_rst_ready2", 256'(d_ir), 256'(1));
    chk("d_rst_state2", 256'(d_os), 256'(0));
    chk("d_rst_tag2", 256'(d_ot), 256'(0));
    d_or = 1;
    repeat (6) tick();
    chk("d_rst_quiet", 256'(d_ov), 256'(0));

`ifdef SHIFT_ROWS_PARITY_EN
    // ---- upset a bit in stage 1 of the NB=8 pipe, then send a clean block
    b_or = 1; dec = 0; tag = 4'h5;
    b_is = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    b_iv = 1;
    tick(); b_iv = 0;
    tick();
    dut_b.state_reg[1][0] = ~dut_b.state_reg[1][0];
    e2 = qb.pop_front();
    e2.st[0] = ~e2.st[0];
    qb.push_front(e2);
    tick();
    chk("b_par_err_hit", 256'(b_pe), 256'(1));
    tag = 4'h6;
    b_is = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    b_iv = 1;
    tick(); b_iv = 0;
    tick(); tick();
    chk("b_par_clean_valid", 256'(b_ov), 256'(1));
    chk("b_par_err_clean", 256'(b_pe), 256'(0));
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
